// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg
//   Shared definitions for the PLL lock detector: FSM state encoding,
//   default parameter values and counter-width helpers.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } pll_state_e;

  localparam int unsigned DEF_WINDOW    = 1000;
  localparam int unsigned DEF_EXP_EDGES = 16;
  localparam int unsigned DEF_TOL       = 1;
  localparam int unsigned DEF_LOCK_CNT  = 4;
  localparam int unsigned DEF_CNT_W     = 16;

  // Window counter runs 0..WINDOW-1.
  function automatic int unsigned win_cnt_width(input int unsigned window);
    return $clog2(window);
  endfunction

  // Good-window counter must be able to hold LOCK_CNT itself.
  function automatic int unsigned good_cnt_width(input int unsigned lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/pll_lock_detect_sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous clock-like signal into the clk_tb domain and
//   produces a single-cycle strobe for each rising edge.
//   Ports:
//     clk_tb  - sampling clock
//     rst_n   - async active-low reset, clears all flops to 0
//     async_i - asynchronous input (monitored clock)
//     edge_o  - one-cycle strobe per rising edge of async_i
module sync_edge_det (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  // meta_q may go metastable; s1_q is the synchronized level, s2_q its
  // one-cycle history for edge detection.
  logic meta_q, s1_q, s2_q;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= async_i;
      s1_q   <= meta_q;
      s2_q   <= s1_q;
    end
  end

  assign edge_o = s1_q & ~s2_q;

endmodule

// File: rtl/pll_lock_detect.sv
// pll_lock_detect
//   Frequency-comparison lock detector. Counts rising edges of mon_clk over
//   fixed windows of WINDOW clk_tb cycles; declares lock after LOCK_CNT
//   consecutive windows within EXP_EDGES +/- TOL, drops lock on the first
//   window outside tolerance.
//   Ports:
//     clk_tb    - detector clock (> 2x mon_clk)
//     rst_n     - async active-low reset
//     mon_clk   - monitored clock, asynchronous
//     pll_rst   - sync; high forces unlock and holds the detector idle
//     pll_lock  - registered lock status
//     lock_lost - one-cycle pulse when lock is dropped by a bad window
//     win_valid - one-cycle pulse per completed window
//     win_edges - edge count of the last completed window
module pll_lock_detect
  import pll_mon_pkg::*;
#(
  parameter int unsigned WINDOW    = DEF_WINDOW,
  parameter int unsigned EXP_EDGES = DEF_EXP_EDGES,
  parameter int unsigned TOL       = DEF_TOL,
  parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             pll_rst,
  output logic             pll_lock,
  output logic             lock_lost,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_edges
);

  localparam int unsigned WCW = win_cnt_width(WINDOW);
  localparam int unsigned GCW = good_cnt_width(LOCK_CNT);
  localparam int unsigned XW  = CNT_W + 1;

  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WINDOW - 1);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_CNT - 1);
  localparam logic [XW-1:0]  EXP_X     = XW'(EXP_EDGES);
  localparam logic [XW-1:0]  TOL_X     = XW'(TOL);

  pll_state_e       state_q, state_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [GCW-1:0]   good_cnt_q, good_cnt_d;
  logic             pll_lock_q, pll_lock_d;
  logic             lock_lost_q, lock_lost_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_edges_q, win_edges_d;

  logic             mon_edge;
  logic [XW-1:0]    sum_x, meas_x, diff_x;
  logic [CNT_W-1:0] meas;
  logic             win_close, good;

  sync_edge_det u_sync (
    .clk_tb  (clk_tb),
    .rst_n   (rst_n),
    .async_i (mon_clk),
    .edge_o  (mon_edge)
  );

  // Running count including this cycle's edge, saturating at all-ones.
  assign sum_x  = {1'b0, edge_cnt_q} + XW'(mon_edge);
  assign meas   = sum_x[CNT_W] ? {CNT_W{1'b1}} : sum_x[CNT_W-1:0];
  assign meas_x = {1'b0, meas};

  // Absolute deviation, kept unsigned by ordering the operands.
  assign diff_x = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
  assign good   = (diff_x <= TOL_X);

  assign win_close = (state_q != ST_IDLE) && (win_cnt_q == WIN_LAST);

  // State register
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (pll_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: if (win_close && good && (good_cnt_q == GOOD_LAST)) state_d = ST_LOCKED;
        ST_LOCKED:  if (win_close && !good) state_d = ST_ACQUIRE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    win_cnt_d   = win_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    good_cnt_d  = good_cnt_q;
    pll_lock_d  = pll_lock_q;
    lock_lost_d = 1'b0;
    win_valid_d = 1'b0;
    win_edges_d = win_edges_q;
    if (pll_rst) begin
      // Partial window is discarded; win_edges keeps the last full result.
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      pll_lock_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      pll_lock_d = 1'b0;
    end else if (win_close) begin
      win_cnt_d   = '0;
      edge_cnt_d  = '0;
      win_edges_d = meas;
      win_valid_d = 1'b1;
      if (state_q == ST_ACQUIRE) begin
        if (good) begin
          good_cnt_d = good_cnt_q + 1'b1;
          if (good_cnt_q == GOOD_LAST) pll_lock_d = 1'b1;
        end else begin
          good_cnt_d = '0;
        end
      end else if (!good) begin
        pll_lock_d  = 1'b0;
        lock_lost_d = 1'b1;
        good_cnt_d  = '0;
      end
    end else begin
      win_cnt_d  = win_cnt_q + 1'b1;
      edge_cnt_d = meas;
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      good_cnt_q  <= '0;
      pll_lock_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_edges_q <= '0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      good_cnt_q  <= good_cnt_d;
      pll_lock_q  <= pll_lock_d;
      lock_lost_q <= lock_lost_d;
      win_valid_q <= win_valid_d;
      win_edges_q <= win_edges_d;
    end
  end

  assign pll_lock  = pll_lock_q;
  assign lock_lost = lock_lost_q;
  assign win_valid = win_valid_q;
  assign win_edges = win_edges_q;

endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect
//   Scoreboard bench: the stimulus process pushes the expected result of each
//   window (edge range, lock/lost flags, exact close cycle); a monitor pops
//   and compares on every win_valid pulse.
`timescale 1ns/1ps
module tb_pll_lock_detect;

  logic        clk_tb  = 1'b0;
  logic        rst_n   = 1'b0;
  logic        mon_clk = 1'b0;
  logic        pll_rst = 1'b0;
  logic        pll_lock, lock_lost, win_valid;
  logic [15:0] win_edges;

  pll_lock_detect dut (
    .clk_tb    (clk_tb),
    .rst_n     (rst_n),
    .mon_clk   (mon_clk),
    .pll_rst   (pll_rst),
    .pll_lock  (pll_lock),
    .lock_lost (lock_lost),
    .win_valid (win_valid),
    .win_edges (win_edges)
  );

  always #1 clk_tb = ~clk_tb;

  // Monitored clock; 0.3 ns offset keeps its edges off the clk_tb grid.
  realtime mon_half = 62.5;
  bit      mon_run  = 1'b1;
  initial begin
    #0.3;
    forever begin
      #(mon_half);
      if (mon_run) mon_clk = ~mon_clk;
    end
  end

  int cyc = 0;
  always @(posedge clk_tb) cyc <= cyc + 1;

  typedef struct {
    int lo;
    int hi;
    bit lock;
    bit lost;
    int at;
  } exp_t;

  exp_t q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   stray    = 0;
  int   rise_cyc = -1;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic push(input int lo, input int hi, input bit lock, input bit lost, input int at);
    exp_t e;
    e.lo = lo; e.hi = hi; e.lock = lock; e.lost = lost; e.at = at;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per completed window.
  initial begin
    int   prev_v   = -1;
    logic lock_prv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk_tb);
      if (!rst_n || pll_rst) prev_v = -1;
      if (pll_lock && !lock_prv) rise_cyc = cyc;
      lock_prv = pll_lock;
      if (win_valid) begin
        if (prev_v >= 0) chk("win_spacing", cyc - prev_v, 1000, 1000);
        prev_v = cyc;
        if (q.size() == 0) begin
          chk("unexpected_window", cyc, -1, -1);
        end else begin
          e = q.pop_front();
          chk("win_edges", int'(win_edges), e.lo, e.hi);
          chk("pll_lock_at_close", int'(pll_lock), int'(e.lock), int'(e.lock));
          chk("lock_lost_at_close", int'(lock_lost), int'(e.lost), int'(e.lost));
          chk("win_close_cycle", cyc, e.at, e.at);
        end
      end else if (lock_lost) begin
        stray++;
      end
    end
  end

  task automatic drain(input string name);
    int budget;
    int n;
    budget = q.size() * 1000 + 2000;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk_tb);
      n++;
    end
    chk({"drain_", name}, q.size(), 0, 0);
    q.delete();
  endtask

  task automatic hold_rst(input int n);
    @(negedge clk_tb);
    pll_rst = 1'b1;
    repeat (n) @(negedge clk_tb);
  endtask

  task automatic release_rst(output int rel);
    @(negedge clk_tb);
    pll_rst = 1'b0;
    rel = cyc;
  endtask

  initial begin
    int rel;
    int saved_rise;

    // Async reset with mon_clk running: everything must stay quiet.
    repeat (100) @(negedge clk_tb);
    chk("rst_pll_lock", int'(pll_lock), 0, 0);
    chk("rst_lock_lost", int'(lock_lost), 0, 0);
    chk("rst_win_valid", int'(win_valid), 0, 0);
    chk("rst_win_edges", int'(win_edges), 0, 0);

    // 8 MHz: four good windows then lock, first close 1001 after release.
    @(negedge clk_tb);
    rst_n = 1'b1;
    rel = cyc;
    for (int i = 1; i <= 4; i++) push(15, 17, (i == 4), 1'b0, rel + 1 + 1000 * i);
    drain("lock_8mhz");
    chk("lock_rise_8mhz", rise_cyc - rel, 4001, 4001);

    // One more good window, then drop to 4 MHz at a window boundary.
    push(15, 17, 1'b1, 1'b0, rel + 5001);
    drain("locked_hold");
    mon_half = 125.0;
    push(7, 9, 1'b0, 1'b1, rel + 6001);
    push(7, 9, 1'b0, 1'b0, rel + 7001);
    push(7, 9, 1'b0, 1'b0, rel + 8001);
    drain("lose_4mhz");

    // pll_rst pulse, back to 8 MHz, lock again.
    hold_rst(20);
    mon_half = 62.5;
    chk("pll_rst_hold_lock", int'(pll_lock), 0, 0);
    release_rst(rel);
    for (int i = 1; i <= 4; i++) push(15, 17, (i == 4), 1'b0, rel + 1 + 1000 * i);
    drain("relock_8mhz");
    chk("lock_rise_after_pll_rst", rise_cyc - rel, 4001, 4001);

    // pll_rst mid-window while locked: immediate unlock, no partial window.
    repeat (300) @(negedge clk_tb);
    pll_rst = 1'b1;
    @(negedge clk_tb);
    chk("midwin_rst_lock", int'(pll_lock), 0, 0);
    chk("midwin_rst_lost", int'(lock_lost), 0, 0);
    chk("midwin_win_edges_held", int'(win_edges), 15, 17);
    repeat (50) @(negedge clk_tb);
    release_rst(rel);
    for (int i = 1; i <= 4; i++) push(15, 17, (i == 4), 1'b0, rel + 1 + 1000 * i);
    drain("relock_midwin");
    chk("lock_rise_midwin", rise_cyc - rel, 4001, 4001);

    // 118 ns period: 16-17 edges, within tolerance, stays locked.
    hold_rst(200);
    mon_half = 59.0;
    release_rst(rel);
    for (int i = 1; i <= 6; i++) push(16, 17, (i >= 4), 1'b0, rel + 1 + 1000 * i);
    drain("tol_118ns");
    chk("lock_rise_118ns", rise_cyc - rel, 4001, 4001);
    saved_rise = rise_cyc;

    // 100 ns period: 20 edges, never locks.
    hold_rst(200);
    mon_half = 50.0;
    release_rst(rel);
    for (int i = 1; i <= 5; i++) push(19, 21, 1'b0, 1'b0, rel + 1 + 1000 * i);
    drain("tol_100ns");
    chk("no_rise_100ns", rise_cyc, saved_rise, saved_rise);

    // mon_clk stopped: empty windows, no lock.
    hold_rst(200);
    mon_run = 1'b0;
    repeat (100) @(negedge clk_tb);
    release_rst(rel);
    for (int i = 1; i <= 3; i++) push(0, 0, 1'b0, 1'b0, rel + 1 + 1000 * i);
    drain("stopped_clk");
    chk("stopped_lock", int'(pll_lock), 0, 0);

    hold_rst(5);
    chk("stray_lock_lost", stray, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
